id_stage_hazard: RTL and testbench
==================================

// Module: id_stage_hazard
// PURPOSE
//  Parametrised instruction-decode stage: decodes MIPS-style 32-bit instructions and reads a
//  bypassed register file. Detects load-use hazards, inserts bubbles and supports flush.
//  Registers the result into an ID/EX pipeline register with a valid bit.
//  Sits between the IF/ID register and the EX stage. Consumes the write-back port from WB.
// PARAMETERS
//  DATA_W     32  datapath width (>=16); register, npc and immediate width
//  NUM_REGS   32  architectural registers (power of 2, 2..32); r0 hardwired to zero
//  HAZARD_EN  1   1 = load-use detection active; 0 = stall_out tied low
// PORTS
//  CLK            in   1       clock, rising edge
//  RST            in   1       asynchronous, active-high reset
//  if_valid_in    in   1       instruction_in/npc_in hold a valid instruction
//  instruction_in in   32      instruction from IF/ID
//  npc_in         in   DATA_W  PC+4 from IF/ID
//  flush_in       in   1       squash the instruction currently in ID (taken branch/jump)
//  wb_regwrite_in in   1       WB write enable
//  wb_waddr_in    in   5       WB destination register
//  wb_wdata_in    in   DATA_W  WB write data
//  stall_out      out  1       combinational; IF and IF/ID must hold this cycle
//  ex_valid_out   out  1       ID/EX holds a real instruction
//  branch_eq_out, branch_ne_out, jump_out, alusrc_out, memread_out, memwrite_out,
//  regwrite_out, regdst_out, memtoreg_out   out  1 each   registered controls
//  aluop_out      out  2       00 add, 01 sub, 10 R-type (use funct), 11 I-logic (use opcode)
//  npc_out, readdata1_out, readdata2_out, imm_out  out  DATA_W  registered datapath
//  rs_out, rt_out, rd_out  out  5  registered register fields (for EX forwarding)
//  illegal_out    out  1       registered; the instruction entering EX had an unknown opcode
// BEHAVIOUR
//  Reset: all outputs 0 and all registers 0. Asynchronous reset takes effect mid-cycle.
//  Regfile: write on CLK rise when wb_regwrite_in and wb_waddr_in!=0 and wb_waddr_in<NUM_REGS.
//   Reads are combinational. Address 0 or >=NUM_REGS reads 0. Write-through bypass: when WB
//   writes an address this cycle, reading that address returns wb_wdata_in.
//  Decode by opcode (insn[31:26]):
//   00 R-type: regwrite, regdst, aluop=10
//   23 lw: memread, memtoreg, regwrite, alusrc, aluop=00
//   2B sw: memwrite, alusrc, aluop=00
//   04 beq: branch_eq, aluop=01
//   05 bne: branch_ne, aluop=01
//   02 j: jump
//   08 addi: regwrite, alusrc, aluop=00
//   0C andi / 0D ori: regwrite, alusrc, aluop=11
//   Any other opcode: all controls 0, illegal flagged.
//  Immediate: andi/ori zero-extend insn[15:0]; all others sign-extend it to DATA_W.
//   j places insn[25:0] zero-extended (truncated if DATA_W<26) in imm_out.
//  Hazard (HAZARD_EN=1): hz = ex_valid_out & memread_out & rt_out!=0 & if_valid_in &
//   (rt_out==insn[25:21] | (rt_out==insn[20:16] & opcode in {00,2B,04,05})).
//   stall_out = hz & ~flush_in.
//  ID/EX update, 1-cycle latency, priority order:
//   1) flush_in: bubble.
//   2) stall_out: bubble; IF/ID holds the instruction, which re-decodes next cycle.
//   3) if_valid_in=0: bubble.
//   4) Otherwise: load the decoded values and set ex_valid_out=1.
//   A bubble sets ex_valid_out=0, all controls=0 and illegal_out=0. Datapath fields
//   (npc/readdata/imm/rs/rt/rd) are don't-care but must be driven deterministically.
//  flush_in and a hazard in the same cycle: flush wins and stall_out=0.
//  A WB write and a stalled re-decode: the bypass guarantees the fresh value on re-decode.
// TESTING
//  1) Reset: pulse RST mid-cycle -> all outputs 0 immediately; regfile reads 0 afterwards.
//  2) WB writes r5=0x1234 while ID decodes add r3,r5,r5 -> next cycle readdata1/2=0x1234.
//     A write to r0 is ignored.
//  3) lw r2,0(r1) then add r4,r2,r3 -> stall_out=1 for exactly 1 cycle.
//     The bubble has ex_valid_out=0. The add reaches EX the following cycle with rs_out=2.
//  4) flush_in=1 with a hazard present -> stall_out=0, ex_valid_out=0 next cycle,
//     regwrite_out=0.
//  5) ori 0x8000 -> imm_out=0x00008000. addi 0x8000 -> imm_out=0xFFFF8000. Opcode 0x3F ->
//     controls 0, illegal_out=1.
//  6) Param sweep DATA_W=16, NUM_REGS=8: write r9 ignored, read r9=0, beq sets aluop=01.

Source files
------------

// File: rtl/id_stage_hazard.sv
// Instruction-decode stage: MIPS-style decode, write-through register file,
// load-use stall / flush handling, registered into an ID/EX pipeline register.
module id_stage_hazard #(
   parameter int DATA_W    = 32,
   parameter int NUM_REGS  = 32,
   parameter int HAZARD_EN = 1
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              if_valid_in,
   input  logic [31:0]       instruction_in,
   input  logic [DATA_W-1:0] npc_in,
   input  logic              flush_in,
   input  logic              wb_regwrite_in,
   input  logic [4:0]        wb_waddr_in,
   input  logic [DATA_W-1:0] wb_wdata_in,
   output logic              stall_out,
   output logic              ex_valid_out,
   output logic              branch_eq_out,
   output logic              branch_ne_out,
   output logic              jump_out,
   output logic              alusrc_out,
   output logic              memread_out,
   output logic              memwrite_out,
   output logic              regwrite_out,
   output logic              regdst_out,
   output logic              memtoreg_out,
   output logic [1:0]        aluop_out,
   output logic [DATA_W-1:0] npc_out,
   output logic [DATA_W-1:0] readdata1_out,
   output logic [DATA_W-1:0] readdata2_out,
   output logic [DATA_W-1:0] imm_out,
   output logic [4:0]        rs_out,
   output logic [4:0]        rt_out,
   output logic [4:0]        rd_out,
   output logic              illegal_out
);

   localparam int         AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   localparam logic [5:0] NR = 6'(NUM_REGS);

   typedef enum logic [5:0] {
      OP_RTYPE = 6'h00,
      OP_J     = 6'h02,
      OP_BEQ   = 6'h04,
      OP_BNE   = 6'h05,
      OP_ADDI  = 6'h08,
      OP_ANDI  = 6'h0C,
      OP_ORI   = 6'h0D,
      OP_LW    = 6'h23,
      OP_SW    = 6'h2B
   } opcode_e;

   typedef struct packed {
      logic              valid;
      logic              branch_eq;
      logic              branch_ne;
      logic              jump;
      logic              alusrc;
      logic              memread;
      logic              memwrite;
      logic              regwrite;
      logic              regdst;
      logic              memtoreg;
      logic [1:0]        aluop;
      logic              illegal;
      logic [DATA_W-1:0] npc;
      logic [DATA_W-1:0] rd1;
      logic [DATA_W-1:0] rd2;
      logic [DATA_W-1:0] imm;
      logic [4:0]        rs;
      logic [4:0]        rt;
      logic [4:0]        rd;
   } idex_t;

   logic [DATA_W-1:0] regs [NUM_REGS];
   logic [5:0]        opcode;
   logic [4:0]        rs, rt, rd;
   logic              wb_en;
   logic              uses_rt;
   logic              hz;
   logic              bubble;
   idex_t             idex_d, idex_q;

   assign opcode = instruction_in[31:26];
   assign rs     = instruction_in[25:21];
   assign rt     = instruction_in[20:16];
   assign rd     = instruction_in[15:11];

   function automatic logic in_range(input logic [4:0] a);
      return {1'b0, a} < NR;
   endfunction

   assign wb_en = wb_regwrite_in && (wb_waddr_in != '0) && in_range(wb_waddr_in);

   always_ff @(posedge CLK or posedge RST) begin
      if (RST)
         regs <= '{default: '0};
      else if (wb_en)
         regs[wb_waddr_in[AW-1:0]] <= wb_wdata_in;
   end

   always_comb begin
      idex_d       = '0;
      idex_d.valid = 1'b1;
      idex_d.npc   = npc_in;
      idex_d.rs    = rs;
      idex_d.rt    = rt;
      idex_d.rd    = rd;
      idex_d.imm   = DATA_W'($signed(instruction_in[15:0]));

      // Same-cycle WB write is forwarded so a stalled re-decode sees fresh data
      if (rs != '0 && in_range(rs))
         idex_d.rd1 = (wb_en && wb_waddr_in == rs) ? wb_wdata_in : regs[rs[AW-1:0]];
      if (rt != '0 && in_range(rt))
         idex_d.rd2 = (wb_en && wb_waddr_in == rt) ? wb_wdata_in : regs[rt[AW-1:0]];

      case (opcode)
         OP_RTYPE: begin
            idex_d.regwrite = 1'b1;
            idex_d.regdst   = 1'b1;
            idex_d.aluop    = 2'b10;
         end
         OP_LW: begin
            idex_d.memread  = 1'b1;
            idex_d.memtoreg = 1'b1;
            idex_d.regwrite = 1'b1;
            idex_d.alusrc   = 1'b1;
         end
         OP_SW: begin
            idex_d.memwrite = 1'b1;
            idex_d.alusrc   = 1'b1;
         end
         OP_BEQ: begin
            idex_d.branch_eq = 1'b1;
            idex_d.aluop     = 2'b01;
         end
         OP_BNE: begin
            idex_d.branch_ne = 1'b1;
            idex_d.aluop     = 2'b01;
         end
         OP_J: begin
            idex_d.jump = 1'b1;
            idex_d.imm  = DATA_W'(instruction_in[25:0]);
         end
         OP_ADDI: begin
            idex_d.regwrite = 1'b1;
            idex_d.alusrc   = 1'b1;
         end
         OP_ANDI, OP_ORI: begin
            idex_d.regwrite = 1'b1;
            idex_d.alusrc   = 1'b1;
            idex_d.aluop    = 2'b11;
            idex_d.imm      = DATA_W'(instruction_in[15:0]);
         end
         default: idex_d.illegal = 1'b1;
      endcase
   end

   // Only these formats actually source rt as a register operand
   assign uses_rt   = opcode inside {OP_RTYPE, OP_SW, OP_BEQ, OP_BNE};
   assign hz        = idex_q.valid && idex_q.memread && (idex_q.rt != '0) && if_valid_in &&
                      ((idex_q.rt == rs) || ((idex_q.rt == rt) && uses_rt));
   assign stall_out = (HAZARD_EN != 0) && hz && !flush_in;
   assign bubble    = flush_in || stall_out || !if_valid_in;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST)
         idex_q <= '0;
      else
         idex_q <= bubble ? '0 : idex_d;
   end

   assign ex_valid_out  = idex_q.valid;
   assign branch_eq_out = idex_q.branch_eq;
   assign branch_ne_out = idex_q.branch_ne;
   assign jump_out      = idex_q.jump;
   assign alusrc_out    = idex_q.alusrc;
   assign memread_out   = idex_q.memread;
   assign memwrite_out  = idex_q.memwrite;
   assign regwrite_out  = idex_q.regwrite;
   assign regdst_out    = idex_q.regdst;
   assign memtoreg_out  = idex_q.memtoreg;
   assign aluop_out     = idex_q.aluop;
   assign illegal_out   = idex_q.illegal;
   assign npc_out       = idex_q.npc;
   assign readdata1_out = idex_q.rd1;
   assign readdata2_out = idex_q.rd2;
   assign imm_out       = idex_q.imm;
   assign rs_out        = idex_q.rs;
   assign rt_out        = idex_q.rt;
   assign rd_out        = idex_q.rd;

endmodule

// File: tb/tb_id_stage_hazard.sv
// Randomised + directed bench for id_stage_hazard: a 32/32 instance and a 16/8
// instance share stimulus and are checked against a table-driven reference model.
module tb_id_stage_hazard;

   typedef struct packed {
      logic        valid, beq, bne, j, alusrc, memread, memwrite, regwrite, regdst, memtoreg;
      logic [1:0]  aluop;
      logic        illegal;
      logic [31:0] npc, rd1, rd2, imm;
      logic [4:0]  rs, rt, rd;
   } idex_t;

   logic        CLK, RST;
   logic        if_valid_in, flush_in, wb_regwrite_in;
   logic [31:0] instruction_in, npc_in, wb_wdata_in;
   logic [4:0]  wb_waddr_in;
   logic [15:0] s_npc_in, s_wdata_in;

   logic        b_stall, b_valid, b_beq, b_bne, b_j, b_alusrc, b_mr, b_mw, b_rw, b_rdst, b_m2r, b_ill;
   logic [1:0]  b_aluop;
   logic [31:0] b_npc, b_rd1, b_rd2, b_imm;
   logic [4:0]  b_rs, b_rt, b_rd;
   logic        s_stall, s_valid, s_beq, s_bne, s_j, s_alusrc, s_mr, s_mw, s_rw, s_rdst, s_m2r, s_ill;
   logic [1:0]  s_aluop;
   logic [15:0] s_npc, s_rd1, s_rd2, s_imm;
   logic [4:0]  s_rs, s_rt, s_rd;

   idex_t       obs_b, obs_s, m_b, m_s;
   logic [31:0] rf_b [32];
   logic [31:0] rf_s [32];
   int          n_checks = 0;
   int          n_fail   = 0;
   logic        last_stall;

   assign s_npc_in   = npc_in[15:0];
   assign s_wdata_in = wb_wdata_in[15:0];

   id_stage_hazard #(.DATA_W(32), .NUM_REGS(32), .HAZARD_EN(1)) dut_b (
      .CLK(CLK), .RST(RST), .if_valid_in(if_valid_in), .instruction_in(instruction_in),
      .npc_in(npc_in), .flush_in(flush_in), .wb_regwrite_in(wb_regwrite_in),
      .wb_waddr_in(wb_waddr_in), .wb_wdata_in(wb_wdata_in), .stall_out(b_stall),
      .ex_valid_out(b_valid), .branch_eq_out(b_beq), .branch_ne_out(b_bne), .jump_out(b_j),
      .alusrc_out(b_alusrc), .memread_out(b_mr), .memwrite_out(b_mw), .regwrite_out(b_rw),
      .regdst_out(b_rdst), .memtoreg_out(b_m2r), .aluop_out(b_aluop), .npc_out(b_npc),
      .readdata1_out(b_rd1), .readdata2_out(b_rd2), .imm_out(b_imm), .rs_out(b_rs),
      .rt_out(b_rt), .rd_out(b_rd), .illegal_out(b_ill));

   id_stage_hazard #(.DATA_W(16), .NUM_REGS(8), .HAZARD_EN(1)) dut_s (
      .CLK(CLK), .RST(RST), .if_valid_in(if_valid_in), .instruction_in(instruction_in),
      .npc_in(s_npc_in), .flush_in(flush_in), .wb_regwrite_in(wb_regwrite_in),
      .wb_waddr_in(wb_waddr_in), .wb_wdata_in(s_wdata_in), .stall_out(s_stall),
      .ex_valid_out(s_valid), .branch_eq_out(s_beq), .branch_ne_out(s_bne), .jump_out(s_j),
      .alusrc_out(s_alusrc), .memread_out(s_mr), .memwrite_out(s_mw), .regwrite_out(s_rw),
      .regdst_out(s_rdst), .memtoreg_out(s_m2r), .aluop_out(s_aluop), .npc_out(s_npc),
      .readdata1_out(s_rd1), .readdata2_out(s_rd2), .imm_out(s_imm), .rs_out(s_rs),
      .rt_out(s_rt), .rd_out(s_rd), .illegal_out(s_ill));

   always_comb begin
      obs_b = '{b_valid, b_beq, b_bne, b_j, b_alusrc, b_mr, b_mw, b_rw, b_rdst, b_m2r,
                b_aluop, b_ill, b_npc, b_rd1, b_rd2, b_imm, b_rs, b_rt, b_rd};
      obs_s = '{s_valid, s_beq, s_bne, s_j, s_alusrc, s_mr, s_mw, s_rw, s_rdst, s_m2r,
                s_aluop, s_ill, {16'h0, s_npc}, {16'h0, s_rd1}, {16'h0, s_rd2},
                {16'h0, s_imm}, s_rs, s_rt, s_rd};
   end

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic cmp_idex(input string p, input idex_t o, input idex_t e);
      check_eq({p, ".valid"}, 32'(o.valid), 32'(e.valid));
      check_eq({p, ".ctl"}, 32'({o.beq, o.bne, o.j, o.alusrc, o.memread, o.memwrite, o.regwrite, o.regdst, o.memtoreg}),
                            32'({e.beq, e.bne, e.j, e.alusrc, e.memread, e.memwrite, e.regwrite, e.regdst, e.memtoreg}));
      check_eq({p, ".aluop"}, 32'(o.aluop), 32'(e.aluop));
      check_eq({p, ".illegal"}, 32'(o.illegal), 32'(e.illegal));
      check_eq({p, ".npc"}, o.npc, e.npc);
      check_eq({p, ".rd1"}, o.rd1, e.rd1);
      check_eq({p, ".rd2"}, o.rd2, e.rd2);
      check_eq({p, ".imm"}, o.imm, e.imm);
      check_eq({p, ".regs"}, 32'({o.rs, o.rt, o.rd}), 32'({e.rs, e.rt, e.rd}));
   endtask

   // Reference register read: r0 / out-of-range give 0, a same-cycle write is visible
   function automatic logic [31:0] mread(input logic [4:0] a, input int nr, input logic [31:0] mask,
                                         input logic [31:0] rf [32]);
      if (a == 0 || int'(a) >= nr) return 32'h0;
      if (wb_regwrite_in && wb_waddr_in == a) return wb_wdata_in & mask;
      return rf[a];
   endfunction

   function automatic idex_t mdecode(input logic [31:0] insn, input logic [31:0] npc, input int nr,
                                     input logic [31:0] mask, input logic [31:0] rf [32]);
      idex_t      e;
      logic [8:0] c;   // beq bne j alusrc memread memwrite regwrite regdst memtoreg
      logic [1:0] op2;
      logic       ill;
      e = '0; ill = 1'b0; op2 = 2'b00;
      case (insn[31:26])
         6'h00:        begin c = 9'b000000110; op2 = 2'b10; end
         6'h23:        c = 9'b000110101;
         6'h2B:        c = 9'b000101000;
         6'h04:        begin c = 9'b100000000; op2 = 2'b01; end
         6'h05:        begin c = 9'b010000000; op2 = 2'b01; end
         6'h02:        c = 9'b001000000;
         6'h08:        c = 9'b000100100;
         6'h0C, 6'h0D: begin c = 9'b000100100; op2 = 2'b11; end
         default:      begin c = 9'b0; ill = 1'b1; end
      endcase
      {e.beq, e.bne, e.j, e.alusrc, e.memread, e.memwrite, e.regwrite, e.regdst, e.memtoreg} = c;
      e.valid   = 1'b1;
      e.aluop   = op2;
      e.illegal = ill;
      case (insn[31:26])
         6'h0C, 6'h0D: e.imm = {16'h0, insn[15:0]} & mask;
         6'h02:        e.imm = {6'h0, insn[25:0]} & mask;
         default:      e.imm = {{16{insn[15]}}, insn[15:0]} & mask;
      endcase
      e.npc = npc & mask;
      e.rs  = insn[25:21];
      e.rt  = insn[20:16];
      e.rd  = insn[15:11];
      e.rd1 = mread(e.rs, nr, mask, rf);
      e.rd2 = mread(e.rt, nr, mask, rf);
      return e;
   endfunction

   function automatic logic mstall(input idex_t m, input logic [31:0] insn);
      logic uses_rt;
      uses_rt = (insn[31:26] == 6'h00) || (insn[31:26] == 6'h2B) ||
                (insn[31:26] == 6'h04) || (insn[31:26] == 6'h05);
      return m.valid && m.memread && m.rt != 0 && if_valid_in && !flush_in &&
             (m.rt == insn[25:21] || (uses_rt && m.rt == insn[20:16]));
   endfunction

   // Called at a falling edge; returns at the next falling edge
   task automatic step(input logic [31:0] insn, input logic [31:0] npc, input logic ifv,
                       input logic fl, input logic we, input logic [4:0] wa, input logic [31:0] wd);
      logic  sb, ss;
      idex_t nb, ns;
      instruction_in = insn; npc_in = npc; if_valid_in = ifv; flush_in = fl;
      wb_regwrite_in = we; wb_waddr_in = wa; wb_wdata_in = wd;
      #1;
      sb = mstall(m_b, insn);
      ss = mstall(m_s, insn);
      check_eq("stall", 32'(b_stall), 32'(sb));
      check_eq("s_stall", 32'(s_stall), 32'(ss));
      last_stall = sb;
      nb = (fl || sb || !ifv) ? '0 : mdecode(insn, npc, 32, 32'hFFFF_FFFF, rf_b);
      ns = (fl || ss || !ifv) ? '0 : mdecode(insn, npc, 8, 32'h0000_FFFF, rf_s);
      if (we && wa != 0)         rf_b[wa] = wd;
      if (we && wa != 0 && wa < 8) rf_s[wa] = wd & 32'h0000_FFFF;
      m_b = nb;
      m_s = ns;
      @(posedge CLK);
      #1;
      cmp_idex("b", obs_b, m_b);
      cmp_idex("s", obs_s, m_s);
      @(negedge CLK);
   endtask

   task automatic model_reset();
      m_b = '0; m_s = '0;
      for (int i = 0; i < 32; i++) begin
         rf_b[i] = '0;
         rf_s[i] = '0;
      end
   endtask

   task automatic midcycle_reset();
      #2 RST = 1'b1;
      #1;
      model_reset();
      cmp_idex("rst_b", obs_b, '0);
      cmp_idex("rst_s", obs_s, '0);
      check_eq("rst_stall", 32'(b_stall), 32'h0);
      @(negedge CLK);
      RST = 1'b0;
   endtask

   function automatic logic [31:0] rand_insn();
      logic [5:0] op;
      case ($urandom_range(0, 10))
         0: op = 6'h00;  1: op = 6'h23;  2: op = 6'h23;  3: op = 6'h2B;
         4: op = 6'h04;  5: op = 6'h05;  6: op = 6'h02;  7: op = 6'h08;
         8: op = 6'h0C;  9: op = 6'h0D;
         default: op = 6'($urandom);
      endcase
      return {op, 5'($urandom_range(0, 11)), 5'($urandom_range(0, 11)), 16'($urandom)};
   endfunction

   initial begin
      logic [31:0] insn, npc;
      logic        ifv;
      RST = 1'b1;
      if_valid_in = 0; flush_in = 0; wb_regwrite_in = 0; wb_waddr_in = 0;
      wb_wdata_in = 0; instruction_in = 0; npc_in = 0;
      model_reset();
      @(negedge CLK);
      @(negedge CLK);
      cmp_idex("init_b", obs_b, '0);
      cmp_idex("init_s", obs_s, '0);
      RST = 1'b0;

      // WB bypass into decode; write to r0 ignored
      step({6'h00, 5'd5, 5'd5, 5'd3, 5'd0, 6'h20}, 32'h100, 1, 0, 1, 5'd5, 32'h1234);
      check_eq("byp_rd1", b_rd1, 32'h1234);
      check_eq("byp_rd2", b_rd2, 32'h1234);
      step({6'h00, 5'd0, 5'd5, 5'd3, 5'd0, 6'h20}, 32'h104, 1, 0, 1, 5'd0, 32'hDEAD);
      check_eq("r0_rd1", b_rd1, 32'h0);

      // Load-use: one stall cycle, then the add issues
      step({6'h23, 5'd1, 5'd2, 16'h0}, 32'h108, 1, 0, 0, 5'd0, 32'h0);
      step({6'h00, 5'd2, 5'd3, 5'd4, 5'd0, 6'h20}, 32'h10C, 1, 0, 0, 5'd0, 32'h0);
      check_eq("lu_stall", 32'(last_stall), 32'h1);
      check_eq("lu_bubble", 32'(b_valid), 32'h0);
      step({6'h00, 5'd2, 5'd3, 5'd4, 5'd0, 6'h20}, 32'h10C, 1, 0, 0, 5'd0, 32'h0);
      check_eq("lu_nostall", 32'(last_stall), 32'h0);
      check_eq("lu_valid", 32'(b_valid), 32'h1);
      check_eq("lu_rs", 32'(b_rs), 32'h2);

      // Flush beats hazard
      step({6'h23, 5'd1, 5'd2, 16'h0}, 32'h110, 1, 0, 0, 5'd0, 32'h0);
      step({6'h00, 5'd2, 5'd3, 5'd4, 5'd0, 6'h20}, 32'h114, 1, 1, 0, 5'd0, 32'h0);
      check_eq("fl_stall", 32'(last_stall), 32'h0);
      check_eq("fl_valid", 32'(b_valid), 32'h0);
      check_eq("fl_regwrite", 32'(b_rw), 32'h0);

      // Immediate extension and illegal opcode
      step({6'h0D, 5'd0, 5'd1, 16'h8000}, 32'h118, 1, 0, 0, 5'd0, 32'h0);
      check_eq("ori_imm", b_imm, 32'h0000_8000);
      step({6'h08, 5'd0, 5'd1, 16'h8000}, 32'h11C, 1, 0, 0, 5'd0, 32'h0);
      check_eq("addi_imm", b_imm, 32'hFFFF_8000);
      step({6'h3F, 26'h3FF_FFFF}, 32'h120, 1, 0, 0, 5'd0, 32'h0);
      check_eq("ill_flag", 32'(b_ill), 32'h1);
      check_eq("ill_rw", 32'(b_rw), 32'h0);

      // Narrow instance: r9 does not exist
      step({6'h00, 5'd1, 5'd1, 5'd1, 5'd0, 6'h20}, 32'h124, 1, 0, 1, 5'd9, 32'h5555);
      step({6'h00, 5'd9, 5'd9, 5'd1, 5'd0, 6'h20}, 32'h128, 1, 0, 0, 5'd0, 32'h0);
      check_eq("s_r9", 32'(s_rd1), 32'h0);
      check_eq("b_r9", b_rd1, 32'h5555);
      step({6'h04, 5'd1, 5'd2, 16'h4}, 32'h12C, 1, 0, 0, 5'd0, 32'h0);
      check_eq("s_beq_aluop", 32'(s_aluop), 32'h1);

      // Mid-cycle reset clears the register file too
      midcycle_reset();
      step({6'h00, 5'd5, 5'd9, 5'd3, 5'd0, 6'h20}, 32'h200, 1, 0, 0, 5'd0, 32'h0);
      check_eq("rst_rf5", b_rd1, 32'h0);
      check_eq("rst_rf9", b_rd2, 32'h0);

      // Random traffic; IF/ID holds its contents while stalled
      insn = rand_insn(); npc = 32'h400; ifv = 1'b1;
      for (int i = 0; i < 600; i++) begin
         if (i == 300) midcycle_reset();
         if (!last_stall) begin
            insn = rand_insn();
            npc  = npc + 32'd4;
            ifv  = ($urandom_range(0, 7) != 0);
         end
         step(insn, npc, ifv, ($urandom_range(0, 9) == 0), 1'($urandom),
              5'($urandom_range(0, 15)), $urandom);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
